// File: rtl/cla8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cla8_seq_ctrl
// Time-shares one external 8-bit carry-lookahead adder between two requesters.
// Operands of 8*NBYTES bits are added or subtracted one byte per cycle,
// least significant byte first. The inter-byte carry is held in a register.
// The result is returned with carry, signed-overflow and zero flags.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[1:0]        request valid, bit i = requester i
//   req_ready[1:0]        grant this cycle (IDLE only, one-hot or zero)
//   req_sub[1:0]          bit i: requester i wants a - b
//   req_a0/req_b0         operands of requester 0
//   req_a1/req_b1         operands of requester 1
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                requester owning the result
//   rsp_sum               result
//   rsp_carry             final carry out (subtract: 1 = no borrow)
//   rsp_ovf, rsp_zero     signed overflow, result == 0
//   busy                  controller not idle
//   cla_a/cla_b/cla_cin   byte operands and carry to the shared adder
//   cla_sum/cla_cout      shared adder result
// ---------------------------------------------------------------------------
module cla8_seq_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_sub,
  input  logic [8*NBYTES-1:0]   req_a0,
  input  logic [8*NBYTES-1:0]   req_b0,
  input  logic [8*NBYTES-1:0]   req_a1,
  input  logic [8*NBYTES-1:0]   req_b1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_carry,
  output logic                  rsp_ovf,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic [7:0]            cla_a,
  output logic [7:0]            cla_b,
  output logic                  cla_cin,
  input  logic [7:0]            cla_sum,
  input  logic                  cla_cout
);

  localparam int unsigned W     = 8 * NBYTES;
  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_rr;
  logic             r_id;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;

  logic             w_any_req;
  logic             w_grant;
  logic             w_accept;
  logic             w_last;
  logic             w_rsp_fire;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic             w_sel_sub;
  logic [7:0]       w_byte_a;
  logic [7:0]       w_byte_b;

  // Arbitration: round-robin pointer breaks ties, a lone requester always wins
  assign w_any_req  = |req_valid;
  assign w_grant    = (&req_valid) ? r_rr : req_valid[1];
  assign w_accept   = (r_state == S_IDLE) && w_any_req;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_rsp_fire = (r_state == S_DONE) && rsp_ready;

  // Operand mux for the granted requester
  assign w_sel_a   = w_grant ? req_a1 : req_a0;
  assign w_sel_b   = w_grant ? req_b1 : req_b0;
  assign w_sel_sub = w_grant ? req_sub[1] : req_sub[0];

  // Current byte slice presented to the adder
  assign w_byte_a = r_a[{r_idx, 3'b000} +: 8];
  assign w_byte_b = r_b[{r_idx, 3'b000} +: 8];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_any_req)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last)     w_state_nxt = S_DONE;
      S_DONE: if (rsp_ready)  w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; everything not owned by the current state is held at zero
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_sum   = '0;
    rsp_carry = 1'b0;
    rsp_ovf   = 1'b0;
    rsp_zero  = 1'b0;
    busy      = 1'b0;
    cla_a     = 8'd0;
    cla_b     = 8'd0;
    cla_cin   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) req_ready = w_grant ? 2'b10 : 2'b01;
      end
      S_RUN: begin
        busy    = 1'b1;
        cla_a   = w_byte_a;
        cla_b   = w_byte_b;
        cla_cin = r_carry;
      end
      S_DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_id    = r_id;
        rsp_sum   = r_sum;
        rsp_carry = r_carry;
        // b was stored inverted for subtract, so one rule covers both ops
        rsp_ovf   = (r_a[W-1] == r_b[W-1]) && (r_sum[W-1] != r_a[W-1]);
        rsp_zero  = ~|r_sum;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operand capture, byte-serial accumulation and round-robin update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= 1'b0;
      r_id    <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      if (w_accept) begin
        // Subtract as a + ~b + 1: the +1 rides in as the first carry
        r_a     <= w_sel_a;
        r_b     <= w_sel_sub ? ~w_sel_b : w_sel_b;
        r_carry <= w_sel_sub;
        r_id    <= w_grant;
        r_idx   <= '0;
      end
      if (r_state == S_RUN) begin
        r_sum[{r_idx, 3'b000} +: 8] <= cla_sum;
        r_carry                     <= cla_cout;
        if (!w_last) r_idx <= r_idx + IDX_W'(1);
      end
      if (w_rsp_fire) begin
        r_rr <= ~r_id;
      end
    end
  end

endmodule

// File: doc/cla8_seq_ctrl.md
# cla8_seq_ctrl

Sequencing and arbitration controller that time-shares one 8-bit carry-lookahead adder (`carry_lookahead_8b`) between two requesters to perform multi-byte add/subtract. Operands of 8*NBYTES bits are processed one byte per cycle, least significant byte first, with the inter-byte carry held in a register. It sits between the core's execute-stage requesters (ALU, address generation) and the shared adder, and returns the result with carry, overflow and zero flags.

## Interface
- NBYTES, 4, number of byte slices per operation; operand width W = 8*NBYTES; NBYTES >= 1
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_sub  in  2  bit i: requester i wants a - b (else a + b)
- req_a0, req_b0  in  W each  operands from requester 0
- req_a1, req_b1  in  W each  operands from requester 1
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  1  requester that owns the result
- rsp_sum  out  W  result
- rsp_carry  out  1  final carry out (subtract: 1 = no borrow)
- rsp_ovf  out  1  signed overflow
- rsp_zero  out  1  rsp_sum == 0
- busy  out  1  high whenever state != IDLE
- cla_a, cla_b  out  8 each  byte operands to the shared adder
- cla_cin  out  1  carry in to the shared adder
- cla_sum  in  8  adder sum
- cla_cout  in  1  adder carry out

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: if any req_valid bit set, grant one: both valid -> grant requester selected by round-robin pointer rr; one valid -> grant it. req_ready[grant] = 1 combinationally in the same cycle (only in IDLE). On that edge latch a_q = a, b_q = sub ? ~b : b, carry_q = sub, id_q = grant, idx = 0; go to RUN.
- RUN: cla_a = a_q[8*idx +: 8], cla_b = b_q[8*idx +: 8], cla_cin = carry_q. Each edge: sum_q[8*idx +: 8] <= cla_sum, carry_q <= cla_cout, idx <= idx+1. When idx == NBYTES-1, go to DONE instead of incrementing.
- DONE: rsp_valid = 1, rsp_sum = sum_q, rsp_carry = carry_q, rsp_id = id_q, rsp_ovf = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]), rsp_zero = ~|sum_q. Hold all rsp_* stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE and set rr <= ~id_q.
- Outside RUN: cla_a = 0, cla_b = 0, cla_cin = 0.
- Requests are never accepted in RUN or DONE; requesters must hold req_valid and operands until req_ready.
- rr only changes on response handshake; a lone requester may be served back-to-back.
- Adder path is combinational through the external adder; controller adds no register between cla_* and cla_sum/cla_cout capture.

## Timing
- Reset values: state IDLE, rr = 0 (requester 0 first), req_ready = 0 (no valid), rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_carry = 0, rsp_ovf = 0, busy = 0, cla_* = 0.
- Accept at edge T0; RUN in cycles T0+1..T0+NBYTES; rsp_valid rises in cycle T0+NBYTES+1. Latency NBYTES+1 cycles to rsp_valid.
- With rsp_ready tied high: handshake in first DONE cycle, IDLE next cycle, next accept same cycle -> one operation every NBYTES+2 cycles.
- Simultaneous req_valid = 2'b11 after reset: requester 0 first, then 1, alternating while both stay valid.
- rsp_ready low: DONE held indefinitely, no new grant, cla_* stay zero.
- rst_n low at any time (including mid-RUN or DONE): immediate return to reset values; partial result discarded, no response issued.
- NBYTES = 1: RUN lasts exactly one cycle.

## Test plan
- Add, NBYTES=4: req0 a=0x000000FF, b=0x00000001, sub=0 -> after 5 cycles rsp_sum=0x00000100, carry=0, ovf=0, zero=0, id=0; carry propagates byte0->byte1.
- Subtract to zero: req1 a=b=0x12345678, sub=1 -> rsp_sum=0, zero=1, carry=1, ovf=0, id=1.
- Signed overflow/wrap: a=0x7FFFFFFF, b=1 add -> sum=0x80000000, ovf=1, carry=0; a=0xFFFFFFFF, b=1 -> sum=0, carry=1, zero=1, ovf=0.
- Arbitration: both valid from reset, rsp_ready=1 -> grants 0,1,0,1 in order, each req_ready pulse one cycle, rsp_id matches, ops spaced 6 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_* stable, req_ready stays 0, busy=1; release -> handshake, IDLE next cycle.
- Reset mid-RUN: drop rst_n at idx=2 -> all outputs at reset values immediately; after release, new request completes with correct result and rr=0.
